// File: rtl/plusarg_timeout.sv
// Cycle-count watchdog that takes its limit from plusarg_reader.
// A limit of 0 leaves the watchdog permanently idle.
module plusarg_timeout #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] limit,
    input  logic             enable,
    input  logic             progress,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             armed,
    output logic             timeout,
    output logic             timeout_pulse
);

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        IDLE    = 2'd1,
        COUNT   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             pulse_q, pulse_d;
    logic [WIDTH-1:0] count_inc;

    // Never wraps: count_q < limit_q holds while counting.
    assign count_inc = count_q + WIDTH'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= LOAD;
            limit_q <= '0;
            count_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            limit_q <= limit_d;
            count_q <= count_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        limit_d = limit_q;
        count_d = count_q;
        pulse_d = 1'b0;
        if (clear) begin
            state_d = LOAD;
            count_d = '0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    limit_d = limit;
                    count_d = '0;
                    state_d = IDLE;
                end
                IDLE: begin
                    count_d = '0;
                    if (enable && (limit_q != '0)) begin
                        state_d = COUNT;
                    end
                end
                COUNT: begin
                    if (!enable) begin
                        state_d = IDLE;
                        count_d = '0;
                    end else if (progress) begin
                        count_d = '0;
                    end else begin
                        count_d = count_inc;
                        if (count_inc == limit_q) begin
                            state_d = EXPIRED;
                            pulse_d = 1'b1;
                        end
                    end
                end
                EXPIRED: begin
                    count_d = limit_q;
                end
                default: begin
                    state_d = LOAD;
                    count_d = '0;
                end
            endcase
        end
    end

    assign count         = count_q;
    assign armed         = (state_q == COUNT);
    assign timeout       = (state_q == EXPIRED);
    assign timeout_pulse = pulse_q;

endmodule

// File: tb/tb_plusarg_timeout.sv
// Randomised and directed bench for plusarg_timeout.
// Expected values come from a phase/counter reference model.
module tb_plusarg_timeout;

    localparam int WIDTH = 32;

    logic             clock;
    logic             reset_n;
    logic [WIDTH-1:0] limit;
    logic             enable;
    logic             progress;
    logic             clear;
    logic [WIDTH-1:0] count;
    logic             armed;
    logic             timeout;
    logic             timeout_pulse;

    int n_vec;
    int n_err;

    // Reference model: which phase the watchdog is in, and its counter.
    bit      m_loading;
    bit      m_armed;
    bit      m_expired;
    bit      m_pulse;
    longint  m_limit;
    longint  m_cnt;

    plusarg_timeout #(.WIDTH(WIDTH)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .limit         (limit),
        .enable        (enable),
        .progress      (progress),
        .clear         (clear),
        .count         (count),
        .armed         (armed),
        .timeout       (timeout),
        .timeout_pulse (timeout_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_loading = 1'b1;
        m_armed   = 1'b0;
        m_expired = 1'b0;
        m_pulse   = 1'b0;
        m_limit   = 0;
        m_cnt     = 0;
    endtask

    task automatic model_step(input bit e, input bit p, input bit c,
                              input longint lim);
        m_pulse = 1'b0;
        if (c) begin
            m_loading = 1'b1;
            m_armed   = 1'b0;
            m_expired = 1'b0;
            m_cnt     = 0;
        end else if (m_loading) begin
            m_limit   = lim;
            m_cnt     = 0;
            m_loading = 1'b0;
        end else if (m_expired) begin
            m_cnt = m_limit;
        end else if (m_armed) begin
            if (!e) begin
                m_armed = 1'b0;
                m_cnt   = 0;
            end else if (p) begin
                m_cnt = 0;
            end else begin
                m_cnt = m_cnt + 1;
                if (m_cnt == m_limit) begin
                    m_armed   = 1'b0;
                    m_expired = 1'b1;
                    m_pulse   = 1'b1;
                end
            end
        end else begin
            m_cnt = 0;
            if (e && m_limit != 0) m_armed = 1'b1;
        end
    endtask

    task automatic compare_all();
        check("count", 64'(count), 64'(m_cnt));
        check("armed", 64'(armed), 64'(m_armed));
        check("timeout", 64'(timeout), 64'(m_expired));
        check("pulse", 64'(timeout_pulse), 64'(m_pulse));
    endtask

    task automatic cyc(input bit e, input bit p, input bit c);
        longint lim_now;
        enable   = e;
        progress = p;
        clear    = c;
        lim_now  = longint'(limit);
        @(posedge clock);
        model_step(e, p, c, lim_now);
        @(negedge clock);
        compare_all();
    endtask

    task automatic rearm(input logic [WIDTH-1:0] lim);
        limit = lim;
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset_n  = 1'b0;
        limit    = '0;
        enable   = 1'b0;
        progress = 1'b0;
        clear    = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        compare_all();
        reset_n = 1'b1;

        // Limit 0: inert for 100 cycles.
        for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0, 1'b0);

        // Limit 5 straight to expiry, then hold.
        rearm(32'd5);
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b0);
        check("exp5_count", 64'(count), 64'd5);

        // Progress every 4th cycle keeps it alive.
        rearm(32'd5);
        for (int i = 0; i < 40; i++) cyc(1'b1, (i % 4) == 3, 1'b0);
        check("prog_no_to", 64'(timeout), 64'd0);
        // Progress exactly on the would-expire cycle.
        for (int i = 0; i < 5; i++) cyc(1'b1, i == 4, 1'b0);
        check("prog_edge", 64'(count), 64'd0);

        // Limit 3 expiry, then reload 10 via clear.
        rearm(32'd3);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0);
        limit = 32'd10;
        cyc(1'b1, 1'b0, 1'b1);
        check("clr_to_low", 64'(timeout), 64'd0);
        for (int i = 0; i < 14; i++) cyc(1'b1, 1'b0, 1'b0);
        check("exp10_count", 64'(count), 64'd10);

        // Limit 8, drop enable at count 6, re-enable to expiry.
        rearm(32'd8);
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("drop_en_cnt", 64'(count), 64'd0);
        for (int i = 0; i < 11; i++) cyc(1'b1, 1'b0, 1'b0);

        // Max limit: counts, never wraps within this window.
        rearm(32'hFFFF_FFFF);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-count at count 3.
        rearm(32'd8);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0);
        check("pre_rst_cnt", 64'(count), 64'd3);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clock);
        reset_n = 1'b1;
        limit   = 32'd4;
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0);

        // Random traffic, including limit changes without clear.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0)
                limit = WIDTH'($urandom_range(0, 12));
            if ($urandom_range(0, 199) == 0) begin
                #2 reset_n = 1'b0;
                #1;
                model_reset();
                compare_all();
                @(negedge clock);
                reset_n = 1'b1;
            end
            cyc($urandom_range(0, 9) != 0,
                $urandom_range(0, 11) == 0,
                $urandom_range(0, 39) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
